// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - EX-stage branch resolution, redirect generation and optional 2-bit BHT predictor
// Optional feature macro: BRANCH_RESOLVE_BHT_EN (defined: BHT present; undefined: static not-taken).
module branch_resolve #(
    parameter int BHT_IDX_W = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_if_pc,
    output logic        o_pred_taken,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_br,
    input  logic        i_ex_is_jmp,
    input  logic [2:0]  i_ex_funct3,
    input  logic [31:0] i_ex_pc,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    output logic        o_br_un,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_br_cnt,
    output logic [31:0] o_mispred_cnt
);

    logic        w_resolve;
    logic        w_taken;
    logic        w_mispred;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic [31:0] r_br_cnt;
    logic [31:0] r_mispred_cnt;

    // Reset gates the resolve event so nothing escapes combinationally while held.
    assign w_resolve = i_ex_valid & (i_ex_is_br | i_ex_is_jmp) & ~i_reset;

    // BLTU/BGEU need the comparator in unsigned mode.
    assign o_br_un = (i_ex_funct3 == 3'b110) || (i_ex_funct3 == 3'b111);

    // Branch direction from funct3; reserved encodings resolve not-taken.
    always_comb begin
        w_taken = 1'b0;
        case (i_ex_funct3)
            3'b000:         w_taken = i_br_equal;
            3'b001:         w_taken = ~i_br_equal;
            3'b100, 3'b110: w_taken = i_br_less;
            3'b101, 3'b111: w_taken = ~i_br_less;
            default:        w_taken = 1'b0;
        endcase
    end

`ifdef BRANCH_RESOLVE_BHT_EN
    localparam int BHT_ENTRIES = 1 << BHT_IDX_W;

    logic [1:0]           r_bht [0:BHT_ENTRIES-1];
    logic [BHT_IDX_W-1:0] w_rd_idx;
    logic [BHT_IDX_W-1:0] w_wr_idx;
    logic                 w_bht_we;
    logic                 w_unused;

    assign w_rd_idx     = i_if_pc[BHT_IDX_W+1:2];
    assign w_wr_idx     = i_ex_pc[BHT_IDX_W+1:2];
    assign w_bht_we     = w_resolve & i_ex_is_br & ~i_ex_is_jmp;
    // Read returns the stored value; a same-cycle update is not bypassed.
    assign o_pred_taken = r_bht[w_rd_idx][1];
    assign w_mispred    = w_taken ^ i_ex_pred_taken;
    assign w_unused     = ^{i_if_pc[31:BHT_IDX_W+2], i_if_pc[1:0]};

    // Saturating 2-bit counter training; reset leaves every entry weakly not-taken.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_bht_we) begin
            if (w_taken && (r_bht[w_wr_idx] != 2'b11)) begin
                r_bht[w_wr_idx] <= r_bht[w_wr_idx] + 2'd1;
            end else if (!w_taken && (r_bht[w_wr_idx] != 2'b00)) begin
                r_bht[w_wr_idx] <= r_bht[w_wr_idx] - 2'd1;
            end
        end
    end
`else
    logic w_unused;

    // Static not-taken: every taken branch is a mispredict.
    assign o_pred_taken = 1'b0;
    assign w_mispred    = w_taken;
    assign w_unused     = ^{i_if_pc, i_ex_pred_taken};
`endif

    // Redirect selection: jumps always redirect, branches only on mispredict.
    always_comb begin
        w_redirect    = 1'b0;
        w_redirect_pc = 32'h0;
        if (w_resolve) begin
            if (i_ex_is_jmp) begin
                w_redirect    = 1'b1;
                w_redirect_pc = i_ex_target;
            end else begin
                w_redirect    = w_mispred;
                w_redirect_pc = w_taken ? i_ex_target : (i_ex_pc + 32'd4);
            end
        end
    end

    assign o_redirect    = w_redirect;
    assign o_redirect_pc = w_redirect_pc;

    // Event counters; they wrap naturally at 2^32.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_br_cnt      <= 32'h0;
            r_mispred_cnt <= 32'h0;
        end else if (w_resolve) begin
            r_br_cnt <= r_br_cnt + 32'd1;
            if (w_redirect) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign o_br_cnt      = r_br_cnt;
    assign o_mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - scoreboard bench for branch_resolve with directed and random stimulus
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_if_pc;
    logic        o_pred_taken;
    logic        i_ex_valid;
    logic        i_ex_is_br;
    logic        i_ex_is_jmp;
    logic [2:0]  i_ex_funct3;
    logic [31:0] i_ex_pc;
    logic [31:0] i_ex_target;
    logic        i_ex_pred_taken;
    logic        i_br_less;
    logic        i_br_equal;
    logic        o_br_un;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;
    logic [31:0] o_br_cnt;
    logic [31:0] o_mispred_cnt;

    always #5 clk = ~clk;

    branch_resolve #(.BHT_IDX_W(4)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_if_pc(i_if_pc), .o_pred_taken(o_pred_taken),
        .i_ex_valid(i_ex_valid), .i_ex_is_br(i_ex_is_br), .i_ex_is_jmp(i_ex_is_jmp),
        .i_ex_funct3(i_ex_funct3), .i_ex_pc(i_ex_pc), .i_ex_target(i_ex_target),
        .i_ex_pred_taken(i_ex_pred_taken), .i_br_less(i_br_less), .i_br_equal(i_br_equal),
        .o_br_un(o_br_un), .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
        .o_br_cnt(o_br_cnt), .o_mispred_cnt(o_mispred_cnt)
    );

`ifdef BRANCH_RESOLVE_BHT_EN
    localparam bit BHT_ON = 1'b1;
`else
    localparam bit BHT_ON = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic        redirect;
        logic [31:0] rpc;
        logic        br_un;
        logic        pred;
        logic [31:0] brc;
        logic [31:0] misc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    // Reference model state: 16 counters as plain ints, event tallies.
    int          m_bht [16];
    logic [31:0] m_brc;
    logic [31:0] m_misc;

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s.%s: got 0x%08h, required 0x%08h", tag, name, act, req);
        end
    endtask

    function automatic logic outcome(input logic [2:0] f3, input logic less, input logic eq);
        case (f3)
            3'd0:       return eq;
            3'd1:       return !eq;
            3'd4, 3'd6: return less;
            3'd5, 3'd7: return !less;
            default:    return 1'b0;
        endcase
    endfunction

    // One stimulus cycle: drive, predict, push, advance model, step past the edge.
    task automatic cycle(input string tag, input logic rst, input logic valid, input logic br,
                         input logic jmp, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic pt, input logic less,
                         input logic eq, input logic [31:0] ifpc);
        exp_t e;
        logic tk, r;
        int   wi;
        i_reset = rst; i_ex_valid = valid; i_ex_is_br = br; i_ex_is_jmp = jmp;
        i_ex_funct3 = f3; i_ex_pc = pc; i_ex_target = tgt; i_ex_pred_taken = pt;
        i_br_less = less; i_br_equal = eq; i_if_pc = ifpc;

        tk = outcome(f3, less, eq);
        r  = valid && (br || jmp) && !rst;
        e.tag   = tag;
        e.br_un = (f3 == 3'd6) || (f3 == 3'd7);
        e.pred  = BHT_ON ? (m_bht[ifpc[5:2]] >= 2) : 1'b0;
        e.brc   = m_brc;
        e.misc  = m_misc;
        if (!r) begin
            e.redirect = 1'b0; e.rpc = 32'h0;
        end else if (jmp) begin
            e.redirect = 1'b1; e.rpc = tgt;
        end else begin
            e.redirect = BHT_ON ? (tk != pt) : tk;
            e.rpc      = tk ? tgt : pc + 32'd4;
        end
        sb_q.push_back(e);

        if (rst) begin
            m_brc = 0; m_misc = 0;
            foreach (m_bht[i]) m_bht[i] = 1;
        end else if (r) begin
            m_brc = m_brc + 1;
            if (e.redirect) m_misc = m_misc + 1;
            if (br && !jmp && BHT_ON) begin
                wi = pc[5:2];
                if (tk) m_bht[wi] = (m_bht[wi] < 3) ? m_bht[wi] + 1 : 3;
                else    m_bht[wi] = (m_bht[wi] > 0) ? m_bht[wi] - 1 : 0;
            end
        end
        @(posedge clk); #1;
    endtask

    // Monitor: outputs are combinational/registered, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk(e.tag, "redirect",    {31'b0, o_redirect},   {31'b0, e.redirect});
            chk(e.tag, "redirect_pc", o_redirect_pc,          e.rpc);
            chk(e.tag, "br_un",       {31'b0, o_br_un},      {31'b0, e.br_un});
            chk(e.tag, "pred_taken",  {31'b0, o_pred_taken}, {31'b0, e.pred});
            chk(e.tag, "br_cnt",      o_br_cnt,               e.brc);
            chk(e.tag, "mispred_cnt", o_mispred_cnt,          e.misc);
        end
    end

    initial begin
        logic [31:0] rv, pc, ifpc;
        m_brc = 0; m_misc = 0;
        foreach (m_bht[i]) m_bht[i] = 1;
        i_reset = 1'b1; i_ex_valid = 1'b0; i_ex_is_br = 1'b0; i_ex_is_jmp = 1'b0;
        i_ex_funct3 = 3'd0; i_ex_pc = 32'h0; i_ex_target = 32'h0; i_ex_pred_taken = 1'b0;
        i_br_less = 1'b0; i_br_equal = 1'b0; i_if_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        cycle("reset_state", 0, 0, 0, 0, 3'd0, 32'h0,        32'h0,   0, 0, 0, 32'h10);
        cycle("blt_signed",  0, 1, 1, 0, 3'd4, 32'h100,      32'h140, 0, 1, 0, 32'h100);
        cycle("bgeu_unsig",  0, 1, 1, 0, 3'd7, 32'h200,      32'h240, 0, 1, 0, 32'h200);
        cycle("bne_wrap",    0, 1, 1, 0, 3'd1, 32'hFFFFFFFC, 32'h40,  1, 0, 1, 32'h0);
        cycle("post_dir",    0, 0, 0, 0, 3'd0, 32'h0,        32'h0,   0, 0, 0, 32'h10);

        // BHT training at pc 0x10 with the lookup watching the same entry.
        cycle("rst_train",   1, 0, 0, 0, 3'd0, 32'h0,        32'h0,   0, 0, 0, 32'h10);
        cycle("beq_t1",      0, 1, 1, 0, 3'd0, 32'h10,       32'h80,  0, 0, 1, 32'h10);
        cycle("beq_t2",      0, 1, 1, 0, 3'd0, 32'h10,       32'h80,  1, 0, 1, 32'h10);
        for (int k = 0; k < 3; k++)
            cycle("beq_nt",  0, 1, 1, 0, 3'd0, 32'h10,       32'h80,  1, 0, 0, 32'h10);
        cycle("beq_sat",     0, 1, 1, 0, 3'd0, 32'h10,       32'h80,  0, 0, 0, 32'h10);
        cycle("bht_look",    0, 0, 0, 0, 3'd0, 32'h0,        32'h0,   0, 0, 0, 32'h10);

        // Jump with is_br also set, then reset while valid.
        cycle("jal_br",      0, 1, 1, 1, 3'd0, 32'h10,       32'h80,  1, 0, 0, 32'h10);
        cycle("rst_valid",   1, 1, 1, 1, 3'd0, 32'h10,       32'h80,  1, 0, 0, 32'h10);
        cycle("after_rst",   0, 0, 0, 0, 3'd0, 32'h0,        32'h0,   0, 0, 0, 32'h10);

        // Bubble and reserved funct3.
        cycle("bubble",      0, 0, 1, 0, 3'd0, 32'h300,      32'h340, 0, 0, 1, 32'h300);
        cycle("f3_010",      0, 1, 1, 0, 3'd2, 32'h300,      32'h340, 0, 1, 1, 32'h300);
        cycle("f3_011",      0, 1, 1, 0, 3'd3, 32'h300,      32'h340, 1, 1, 1, 32'h300);

        for (int n = 0; n < 600; n++) begin
            rv   = $urandom;
            pc   = $urandom & 32'hFFFF_FFFC;
            if (n % 7 == 0) pc = 32'hFFFF_FFFC;
            ifpc = (rv[1:0] == 2'b00) ? pc : ($urandom & 32'hFFFF_FFFC);
            cycle("random", ($urandom_range(0, 59) == 0), rv[2] | rv[3], rv[4] | rv[5], rv[6] & rv[7],
                  rv[10:8], pc, $urandom, rv[11], rv[12], rv[13], ifpc);
        end

        i_ex_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("end", "queue_left", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
